// File: rtl/func_encoder.sv
// Operation-to-function-byte encoder: requests are queued in a small FIFO and
// drained into a one-entry output stage, dropping WND codes that select the current window.
module func_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [1:0]               req_wnd,
  output logic [7:0]               func,
  output logic                     func_valid,
  input  logic                     func_ready,
  output logic [1:0]               cur_wnd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [2:0]      OP_WND   = 3'd7;
  localparam logic [7:0]      FUNC_NOP = 8'h40;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic          push_p0;
  logic          pop_p0;
  logic          free_p1;
  logic [2:0]    head_op_p0;
  logic [1:0]    head_wnd_p0;
  logic          head_drop_p0;

  function automatic logic [7:0] encode(input logic [2:0] op, input logic [1:0] wnd);
    case (op)
      3'd0:    encode = 8'h01;
      3'd1:    encode = 8'h02;
      3'd2:    encode = 8'h04;
      3'd3:    encode = 8'h08;
      3'd4:    encode = 8'h10;
      3'd5:    encode = 8'h20;
      3'd6:    encode = 8'h40;
      default: encode = {6'b100000, wnd};
    endcase
  endfunction

  always_comb begin
    req_ready    = !rst && (count < FULL_CNT);
    push_p0      = req_valid && req_ready;
    free_p1      = !func_valid || func_ready;
    pop_p0       = free_p1 && (count != '0);
    {head_op_p0, head_wnd_p0} = mem[rptr];
    // A WND entry naming the window already in force carries no information.
    head_drop_p0 = (head_op_p0 == OP_WND) && (head_wnd_p0 == cur_wnd);
  end

  // Stage p0: FIFO storage, written only on accepted requests.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem[wptr] <= {req_op, req_wnd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push_p0) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_p0) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_p0, pop_p0})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1: output register toward the ALU control decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      func       <= FUNC_NOP;
      func_valid <= 1'b0;
      cur_wnd    <= 2'd0;
    end else if (pop_p0 && !head_drop_p0) begin
      func       <= encode(head_op_p0, head_wnd_p0);
      func_valid <= 1'b1;
      if (head_op_p0 == OP_WND) begin
        cur_wnd <= head_wnd_p0;
      end
    end else if (free_p1) begin
      func       <= FUNC_NOP;
      func_valid <= 1'b0;
    end
  end

endmodule
